param_stream_source: RTL and testbench

- Streams a constant parameter tensor (weight or bias) from an on-chip ROM onto a valid/ready output stream.
- Each ROM word holds one block of PARALLELISM_DIM_0*PARALLELISM_DIM_1 elements.
- Supports 2-D tiling, a configurable ROM read latency and a repeat count.
- Honours backpressure without losing or duplicating blocks, using prefetch into a small output FIFO. Sits in front of linear/attention compute cores in place of free-running always-valid sources.

---
 rtl/param_stream_pkg.sv | 16 +
 rtl/param_stream_rom.sv | 23 ++
 rtl/param_stream_source.sv | 110 +++++++++++
 tb/tb_param_stream_source.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/param_stream_pkg.sv
// param_stream_pkg: shared sizing helpers for the parameter stream source
package param_stream_pkg;

    function automatic int blocks(input int t0, input int p0, input int t1, input int p1);
        return (t0 / p0) * (t1 / p1);
    endfunction

    function automatic int fifo_depth(input int rom_latency);
        return rom_latency + 2;
    endfunction

    function automatic int block_width(input int precision, input int p0, input int p1);
        return precision * p0 * p1;
    endfunction

endpackage

// File: rtl/param_stream_rom.sv
// param_stream_rom: read-only block memory with a LATENCY-stage registered read pipeline
module param_stream_rom #(
  parameter int    DWIDTH    = 16,
  parameter int    MEM_SIZE  = 32,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = "",
  parameter int    AWIDTH    = MEM_SIZE > 1 ? $clog2(MEM_SIZE) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic [AWIDTH-1:0] addr,
  output logic [DWIDTH-1:0] q
);
  logic [DWIDTH-1:0] mem  [MEM_SIZE];
  logic [DWIDTH-1:0] pipe [LATENCY];
  always_ff @(posedge clk) begin
    if (en) begin
      pipe[0] <= mem[addr];
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign q = pipe[LATENCY-1];
endmodule

// File: rtl/param_stream_source.sv
// param_stream_source: streams a ROM-held parameter tensor block by block onto a valid/ready stream
module param_stream_source
    import param_stream_pkg::*;
#(
    parameter int    PRECISION         = 16,
    parameter int    TENSOR_SIZE_DIM_0 = 32,
    parameter int    TENSOR_SIZE_DIM_1 = 1,
    parameter int    PARALLELISM_DIM_0 = 1,
    parameter int    PARALLELISM_DIM_1 = 1,
    parameter int    REPEAT            = 0,
    parameter int    ROM_LATENCY       = 2,
    parameter string INIT_FILE         = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restart,
    output logic [PRECISION-1:0] data_out [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 data_out_last,
    output logic                 done
);
    localparam int BLOCKS = blocks(TENSOR_SIZE_DIM_0, PARALLELISM_DIM_0, TENSOR_SIZE_DIM_1, PARALLELISM_DIM_1);
    localparam int DEPTH  = fifo_depth(ROM_LATENCY);
    localparam int DW     = block_width(PRECISION, PARALLELISM_DIM_0, PARALLELISM_DIM_1);
    localparam int AW     = $clog2(BLOCKS) + 1;
    localparam int RAW    = BLOCKS > 1 ? $clog2(BLOCKS) : 1;
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int SW     = $clog2(REPEAT + 1) + 1;

    // fin marks the last block of the final pass so done can follow its pop
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          fin;
    } entry_t;

    logic [AW-1:0]          addr;
    logic [SW-1:0]          pass;
    logic                   active;
    logic [ROM_LATENCY-1:0] v_sr, l_sr, f_sr;
    entry_t                 fifo [DEPTH];
    entry_t                 head;
    logic [PW-1:0]          wptr, rptr;
    logic [CW-1:0]          count;
    logic [DW-1:0]          rom_q;
    logic                   issue, push, pop, last_blk, last_pass;

    param_stream_rom #(
        .DWIDTH(DW), .MEM_SIZE(BLOCKS), .LATENCY(ROM_LATENCY), .INIT_FILE(INIT_FILE)
    ) u_rom (
        .clk(clk), .en(1'b1), .addr(addr[RAW-1:0]), .q(rom_q)
    );

    // reserve FIFO space for every read still in the ROM pipeline
    assign issue          = active && (int'(count) + $countones(v_sr) + 1 <= DEPTH);
    assign last_blk       = addr == AW'(BLOCKS - 1);
    assign last_pass      = REPEAT != 0 && pass == SW'(REPEAT - 1);
    assign push           = v_sr[ROM_LATENCY-1];
    assign head           = fifo[rptr];
    assign data_out_valid = count != '0 && !done;
    assign data_out_last  = data_out_valid && head.last;
    assign pop            = data_out_valid && data_out_ready;

    always_comb
        for (int j = 0; j < PARALLELISM_DIM_0 * PARALLELISM_DIM_1; j++)
            data_out[j] = head.data[PRECISION*j +: PRECISION];

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            addr   <= '0;
            pass   <= '0;
            active <= 1'b1;
            v_sr   <= '0;
            l_sr   <= '0;
            f_sr   <= '0;
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            done   <= 1'b0;
        end else begin
            v_sr[0] <= issue;
            l_sr[0] <= last_blk;
            f_sr[0] <= last_blk && last_pass;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                v_sr[i] <= v_sr[i-1];
                l_sr[i] <= l_sr[i-1];
                f_sr[i] <= f_sr[i-1];
            end
            if (issue) begin
                addr <= last_blk ? '0 : addr + 1'b1;
                if (last_blk) begin
                    pass <= pass + 1'b1;
                    if (last_pass) active <= 1'b0;
                end
            end
            if (push) begin
                fifo[wptr] <= '{data: rom_q, last: l_sr[ROM_LATENCY-1], fin: f_sr[ROM_LATENCY-1]};
                wptr       <= wptr == PW'(DEPTH - 1) ? '0 : wptr + 1'b1;
            end
            if (pop) rptr <= rptr == PW'(DEPTH - 1) ? '0 : rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (pop && head.fin) done <= 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (!rst && !restart) assert (!(push && !pop && count == CW'(DEPTH)));
endmodule

// File: tb/tb_param_stream_source.sv
// tb_param_stream_source: table-driven and randomized checks of the parameter stream source
module tb_param_stream_source;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rs [5];
    logic        rdy[5];
    logic        v  [5];
    logic        l  [5];
    logic        dn [5];
    logic [15:0] o0[2], o1[2], o2[2], o3[4], o4[4];

    int total = 0;
    int bad   = 0;
    int maxc  = 0;

    param_stream_source #(.PRECISION(16), .TENSOR_SIZE_DIM_0(8), .TENSOR_SIZE_DIM_1(1),
        .PARALLELISM_DIM_0(2), .PARALLELISM_DIM_1(1), .REPEAT(0), .ROM_LATENCY(2), .INIT_FILE(""))
    d0 (.clk(clk), .rst(rst), .restart(rs[0]), .data_out(o0), .data_out_valid(v[0]),
        .data_out_ready(rdy[0]), .data_out_last(l[0]), .done(dn[0]));

    param_stream_source #(.PRECISION(16), .TENSOR_SIZE_DIM_0(8), .TENSOR_SIZE_DIM_1(1),
        .PARALLELISM_DIM_0(2), .PARALLELISM_DIM_1(1), .REPEAT(2), .ROM_LATENCY(2), .INIT_FILE(""))
    d1 (.clk(clk), .rst(rst), .restart(rs[1]), .data_out(o1), .data_out_valid(v[1]),
        .data_out_ready(rdy[1]), .data_out_last(l[1]), .done(dn[1]));

    param_stream_source #(.PRECISION(16), .TENSOR_SIZE_DIM_0(8), .TENSOR_SIZE_DIM_1(1),
        .PARALLELISM_DIM_0(2), .PARALLELISM_DIM_1(1), .REPEAT(0), .ROM_LATENCY(4), .INIT_FILE(""))
    d2 (.clk(clk), .rst(rst), .restart(rs[2]), .data_out(o2), .data_out_valid(v[2]),
        .data_out_ready(rdy[2]), .data_out_last(l[2]), .done(dn[2]));

    param_stream_source #(.PRECISION(16), .TENSOR_SIZE_DIM_0(4), .TENSOR_SIZE_DIM_1(2),
        .PARALLELISM_DIM_0(4), .PARALLELISM_DIM_1(1), .REPEAT(0), .ROM_LATENCY(2), .INIT_FILE(""))
    d3 (.clk(clk), .rst(rst), .restart(rs[3]), .data_out(o3), .data_out_valid(v[3]),
        .data_out_ready(rdy[3]), .data_out_last(l[3]), .done(dn[3]));

    param_stream_source #(.PRECISION(16), .TENSOR_SIZE_DIM_0(4), .TENSOR_SIZE_DIM_1(1),
        .PARALLELISM_DIM_0(4), .PARALLELISM_DIM_1(1), .REPEAT(0), .ROM_LATENCY(2), .INIT_FILE(""))
    d4 (.clk(clk), .rst(rst), .restart(rs[4]), .data_out(o4), .data_out_valid(v[4]),
        .data_out_ready(rdy[4]), .data_out_last(l[4]), .done(dn[4]));

    // element j of block b is {b+1, j+1}, so both block order and element slicing are visible
    function automatic logic [63:0] exp_word(input int b, input int ne);
        logic [63:0] w = '0;
        for (int j = 0; j < ne; j++) w[16*j +: 16] = {8'(b + 1), 8'(j + 1)};
        return w;
    endfunction

    function automatic logic exp_last(input int n, input int nb);
        return n % nb == nb - 1;
    endfunction

    function automatic logic [65:0] peek(input int i);
        case (i)
            0:       return {v[0], l[0], 32'h0, o0[1], o0[0]};
            1:       return {v[1], l[1], 32'h0, o1[1], o1[0]};
            2:       return {v[2], l[2], 32'h0, o2[1], o2[0]};
            3:       return {v[3], l[3], o3[3], o3[2], o3[1], o3[0]};
            default: return {v[4], l[4], o4[3], o4[2], o4[1], o4[0]};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [65:0] a, input logic [65:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic pulse_restart(input int i);
        rs[i] = 1'b1;
        @(posedge clk);
        #1 rs[i] = 1'b0;
    endtask

    // accepted block k must be block k mod nb; a stalled head must hold
    task automatic run(input int i, input int nb, input int ne, input int cyc, input int stall,
                       inout int n, input string nm);
        logic [65:0] p, prev;
        logic held = 1'b0;
        prev = '0;
        for (int c = 0; c < cyc; c++) begin
            rdy[i] = $urandom_range(0, 99) >= stall;
            @(negedge clk);
            p = peek(i);
            if (held) chk({nm, "_hold"}, p, prev);
            if (p[65] && rdy[i]) begin
                chk(nm, p, {1'b1, exp_last(n, nb), exp_word(n % nb, ne)});
                n++;
            end
            held = p[65] && !rdy[i];
            prev = p;
            if (i == 0 && int'(d0.count) > maxc) maxc = int'(d0.count);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic first_valid(input int i, input int ne, input int lat, input string nm);
        logic [65:0] p;
        int c;
        rdy[i] = 1'b1;
        for (c = 0; c < 20; c++) begin
            @(negedge clk);
            p = peek(i);
            if (p[65]) break;
            @(posedge clk);
            #1;
        end
        chk({nm, "_lat"}, 66'(c), 66'(lat + 1));
        chk({nm, "_blk"}, p, {2'b10, exp_word(0, ne)});
        chk({nm, "_done"}, 66'(dn[i]), 66'(0));
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rdy;
        logic v;
        int   blk;
        logic last;
    } vec_t;

    vec_t tab[13];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] w;
        logic [65:0] p;
        int n, pop_c;
        for (int i = 0; i < 5; i++) begin
            rs[i]  = 1'b0;
            rdy[i] = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
            w = exp_word(b, 2);
            d0.u_rom.mem[2'(b)] = w[31:0];
            d1.u_rom.mem[2'(b)] = w[31:0];
            d2.u_rom.mem[2'(b)] = w[31:0];
        end
        d3.u_rom.mem[1'b0] = exp_word(0, 4);
        d3.u_rom.mem[1'b1] = exp_word(1, 4);
        d4.u_rom.mem[1'b0] = exp_word(0, 4);

        tab = '{'{1'b1, 1'b0, 0, 1'b0}, '{1'b1, 1'b0, 0, 1'b0}, '{1'b1, 1'b0, 0, 1'b0},
                '{1'b1, 1'b1, 0, 1'b0}, '{1'b1, 1'b1, 1, 1'b0}, '{1'b1, 1'b1, 2, 1'b0},
                '{1'b1, 1'b1, 3, 1'b1}, '{1'b1, 1'b1, 0, 1'b0}, '{1'b1, 1'b1, 1, 1'b0},
                '{1'b0, 1'b1, 2, 1'b0}, '{1'b0, 1'b1, 2, 1'b0}, '{1'b1, 1'b1, 2, 1'b0},
                '{1'b1, 1'b1, 3, 1'b1}};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) chk("reset", 66'({v[i], l[i], dn[i]}), 66'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        for (int c = 0; c < 13; c++) begin
            rdy[0] = tab[c].rdy;
            @(negedge clk);
            p = peek(0);
            chk($sformatf("table_c%0d", c), p[65] ? p : {p[65:64], 64'h0},
                tab[c].v ? {1'b1, tab[c].last, exp_word(tab[c].blk, 2)} : 66'h0);
            @(posedge clk);
            #1;
        end

        rdy[0] = 1'b0;
        pulse_restart(0);
        n = 0;
        run(0, 4, 2, 300, 30, n, "stall");
        chk("stall_progress", 66'(n >= 150), 66'(1));
        chk("stall_fifo_max", 66'(maxc <= 4), 66'(1));

        rdy[0] = 1'b0;
        pulse_restart(0);
        n = 0;
        run(0, 4, 2, 5, 0, n, "rs_pre");
        rdy[0] = 1'b0;
        @(negedge clk);
        chk("rs_head", peek(0), {2'b10, exp_word(2, 2)});
        @(posedge clk);
        #1;
        pulse_restart(0);
        first_valid(0, 2, 2, "rs_idle");
        pulse_restart(0);
        first_valid(0, 2, 2, "rs_handshake");

        pulse_restart(1);
        n = 0;
        pop_c = -100;
        for (int c = 0; c < 45; c++) begin
            rdy[1] = 1'b1;
            @(negedge clk);
            p = peek(1);
            if (c == pop_c + 1) chk("rep_done_set", 66'(dn[1]), 66'(1));
            if (p[65]) begin
                if (n == 7) chk("rep_done_early", 66'(dn[1]), 66'(0));
                chk("rep_blk", p, {1'b1, exp_last(n, 4), exp_word(n % 4, 2)});
                n++;
                if (n == 8) pop_c = c;
            end
            @(posedge clk);
            #1;
        end
        chk("rep_count", 66'(n), 66'(8));
        chk("rep_done_hold", 66'(dn[1]), 66'(1));
        pulse_restart(1);
        @(negedge clk);
        chk("rep_done_clr", 66'(dn[1]), 66'(0));
        @(posedge clk);
        #1;

        rdy[2] = 1'b0;
        pulse_restart(2);
        repeat (50) @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat4_buffered", 66'(d2.count), 66'(6));
        chk("lat4_head", peek(2), {2'b10, exp_word(0, 2)});
        @(posedge clk);
        #1;
        n = 0;
        run(2, 4, 2, 12, 0, n, "lat4_drain");
        chk("lat4_count", 66'(n), 66'(12));

        pulse_restart(3);
        n = 0;
        run(3, 2, 4, 10, 0, n, "blocks2");
        chk("blocks2_count", 66'(n), 66'(7));
        pulse_restart(4);
        n = 0;
        run(4, 1, 4, 10, 0, n, "blocks1");
        chk("blocks1_count", 66'(n), 66'(7));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
